// File: rtl/mouse_pkg.sv
// Shared PS/2 mouse definitions: master FSM state encoding and
// command/response byte constants used by the mouse master sequencer.
package mouse_pkg;

  typedef enum logic [3:0] {
    S_INIT_WAIT     = 4'd0,
    S_SEND_RST      = 4'd1,
    S_WAIT_SENT_RST = 4'd2,
    S_WAIT_ACK1     = 4'd3,
    S_WAIT_BAT      = 4'd4,
    S_WAIT_ID       = 4'd5,
    S_SEND_EN       = 4'd6,
    S_WAIT_SENT_EN  = 4'd7,
    S_WAIT_ACK2     = 4'd8,
    S_RD_STATUS     = 4'd9,
    S_RD_DX         = 4'd10,
    S_RD_DY         = 4'd11,
    S_INTERRUPT     = 4'd12
  } state_t;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;
  localparam int STATUS_SYNC_BIT    = 3;

endpackage

// File: rtl/mouse_master_sm.sv
// PS/2 mouse master sequencer: power-up handshake (FF / FA AA 00 / F4 / FA)
// then 3-byte stream packets latched into MOUSE_STATUS/DX/DY.
// Ports: CLK, RESET (async, high); SEND_BYTE/BYTE_TO_SEND/BYTE_SENT to
// transmitter; READ_ENABLE/BYTE_READ/BYTE_ERROR_CODE/BYTE_READY from
// receiver; MOUSE_* packet outputs, SEND_INTERRUPT pulse, MASTER_STATE.
module mouse_master_sm #(
  parameter int unsigned INIT_WAIT_CYCLES    = 5_000_000,
  parameter int unsigned BYTE_TIMEOUT_CYCLES = 20_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic [3:0] MASTER_STATE
);
  import mouse_pkg::*;

  localparam logic [31:0] INIT_LAST = 32'(INIT_WAIT_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = 32'(BYTE_TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      next;
  logic [31:0] cnt;
  logic [7:0]  sh_status;
  logic [7:0]  sh_dx;
  logic [7:0]  sh_dy;
  logic        irq_pend;
  logic        timeout;
  logic        good;

  assign MASTER_STATE = state;

  // Init-phase byte check: any receiver error or wrong value restarts.
  function automatic state_t chk_rsp(
    input logic [7:0] exp,
    input state_t     ok_state
  );
    if (good && BYTE_READ == exp) return ok_state;
    return S_INIT_WAIT;
  endfunction

  always_comb begin
    next    = state;
    timeout = (cnt >= TO_LAST);
    good    = (BYTE_ERROR_CODE == 2'b00);
    unique case (state)
      S_INIT_WAIT:
        if (cnt >= INIT_LAST) next = S_SEND_RST;
      S_SEND_RST:
        next = S_WAIT_SENT_RST;
      S_WAIT_SENT_RST:
        if (BYTE_SENT)    next = S_WAIT_ACK1;
        else if (timeout) next = S_INIT_WAIT;
      S_WAIT_ACK1:
        if (BYTE_READY)   next = chk_rsp(RSP_ACK, S_WAIT_BAT);
        else if (timeout) next = S_INIT_WAIT;
      S_WAIT_BAT:
        if (BYTE_READY)   next = chk_rsp(RSP_BAT_OK, S_WAIT_ID);
        else if (timeout) next = S_INIT_WAIT;
      S_WAIT_ID:
        if (BYTE_READY)   next = chk_rsp(RSP_ID, S_SEND_EN);
        else if (timeout) next = S_INIT_WAIT;
      S_SEND_EN:
        next = S_WAIT_SENT_EN;
      S_WAIT_SENT_EN:
        if (BYTE_SENT)    next = S_WAIT_ACK2;
        else if (timeout) next = S_INIT_WAIT;
      S_WAIT_ACK2:
        if (BYTE_READY)   next = chk_rsp(RSP_ACK, S_RD_STATUS);
        else if (timeout) next = S_INIT_WAIT;
      // Only a clean byte with the sync bit set starts a packet.
      S_RD_STATUS:
        if (BYTE_READY && good && BYTE_READ[STATUS_SYNC_BIT])
          next = S_RD_DX;
      S_RD_DX:
        if (BYTE_READY)   next = good ? S_RD_DY : S_RD_STATUS;
        else if (timeout) next = S_RD_STATUS;
      S_RD_DY:
        if (BYTE_READY)   next = good ? S_INTERRUPT : S_RD_STATUS;
        else if (timeout) next = S_RD_STATUS;
      S_INTERRUPT:
        next = S_RD_STATUS;
      default:
        next = S_INIT_WAIT;
    endcase
  end

  // Send/enable outputs decode the next state so they line up with
  // the state they belong to while still coming straight from flops.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= S_INIT_WAIT;
      cnt            <= '0;
      SEND_BYTE      <= 1'b0;
      BYTE_TO_SEND   <= '0;
      READ_ENABLE    <= 1'b0;
      sh_status      <= '0;
      sh_dx          <= '0;
      sh_dy          <= '0;
      MOUSE_STATUS   <= '0;
      MOUSE_DX       <= '0;
      MOUSE_DY       <= '0;
      irq_pend       <= 1'b0;
      SEND_INTERRUPT <= 1'b0;
    end else begin
      state <= next;
      cnt   <= (next != state) ? '0 : cnt + 32'd1;

      SEND_BYTE <= (next == S_SEND_RST) || (next == S_SEND_EN);
      if (next == S_SEND_RST)
        BYTE_TO_SEND <= CMD_RESET;
      else if (next == S_SEND_EN)
        BYTE_TO_SEND <= CMD_ENABLE;

      READ_ENABLE <= !(next inside {S_INIT_WAIT, S_SEND_RST, S_SEND_EN});

      if (state == S_RD_STATUS && next == S_RD_DX) sh_status <= BYTE_READ;
      if (state == S_RD_DX && next == S_RD_DY)     sh_dx     <= BYTE_READ;
      if (state == S_RD_DY && next == S_INTERRUPT) sh_dy     <= BYTE_READ;

      // One atomic 24-bit update, interrupt one cycle behind it.
      if (state == S_INTERRUPT) begin
        MOUSE_STATUS <= sh_status;
        MOUSE_DX     <= sh_dx;
        MOUSE_DY     <= sh_dy;
      end
      irq_pend       <= (state == S_INTERRUPT);
      SEND_INTERRUPT <= irq_pend;
    end
  end

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed bench for mouse_master_sm with shrunken wait/timeout params.
// Drives inputs and samples outputs on the falling clock edge.
module tb_mouse_master_sm;

  localparam int INIT = 8;
  localparam int TO   = 40;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ = '0;
  logic [1:0] BYTE_ERROR_CODE = '0;
  logic       BYTE_READY = 1'b0;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic [3:0] MASTER_STATE;

  int errors  = 0;
  int checks  = 0;
  int irq_cnt = 0;

  mouse_master_sm #(
    .INIT_WAIT_CYCLES(INIT),
    .BYTE_TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SEND_BYTE(SEND_BYTE),
    .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE),
    .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS),
    .MOUSE_DX(MOUSE_DX),
    .MOUSE_DY(MOUSE_DY),
    .SEND_INTERRUPT(SEND_INTERRUPT),
    .MASTER_STATE(MASTER_STATE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    #1;
    if (SEND_INTERRUPT) irq_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  function automatic logic [31:0] mouse();
    return {8'h00, MOUSE_STATUS, MOUSE_DX, MOUSE_DY};
  endfunction

  task automatic do_reset();
    RESET = 1'b1;
    BYTE_SENT = 1'b0;
    BYTE_READY = 1'b0;
    BYTE_READ = '0;
    BYTE_ERROR_CODE = '0;
    tick(2);
    RESET = 1'b0;
  endtask

  task automatic wait_send(input string tag,
                           input logic [7:0] exp_b,
                           input int exp_n);
    int n = 0;
    while (!SEND_BYTE && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(exp_n));
    check({tag, "_byte"}, 32'(BYTE_TO_SEND), 32'(exp_b));
  endtask

  task automatic ack_sent();
    tick();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b, input logic [1:0] e = 2'b00);
    BYTE_READ = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY = 1'b1;
    tick();
    BYTE_READY = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic do_init();
    wait_send("i_ff", 8'hFF, INIT);
    ack_sent();
    rx(8'hFA);
    rx(8'hAA);
    rx(8'h00);
    wait_send("i_f4", 8'hF4, 0);
    ack_sent();
    rx(8'hFA);
    check("i_done", 32'(MASTER_STATE), 32'd9);
  endtask

  task automatic wait_idle(input string tag, input int exp_n);
    int n = 0;
    while (MASTER_STATE != 4'd0 && n < 500) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_state", 32'(MASTER_STATE), 32'd0);
    check("rst_send", 32'(SEND_BYTE), 32'd0);
    check("rst_re", 32'(READ_ENABLE), 32'd0);
    check("rst_tx", 32'(BYTE_TO_SEND), 32'd0);
    check("rst_mouse", mouse(), 32'd0);
    check("rst_irq", 32'(SEND_INTERRUPT), 32'd0);
    RESET = 1'b0;

    // Happy init, step by step
    wait_send("ff1", 8'hFF, INIT);
    check("re_send", 32'(READ_ENABLE), 32'd0);
    check("st_send", 32'(MASTER_STATE), 32'd1);
    tick();
    check("send_pulse", 32'(SEND_BYTE), 32'd0);
    check("st_wsent", 32'(MASTER_STATE), 32'd2);
    check("re_wsent", 32'(READ_ENABLE), 32'd1);
    check("hold_ff", 32'(BYTE_TO_SEND), 32'hFF);
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
    check("st_ack1", 32'(MASTER_STATE), 32'd3);
    rx(8'hFA);
    check("st_bat", 32'(MASTER_STATE), 32'd4);
    rx(8'hAA);
    check("st_id", 32'(MASTER_STATE), 32'd5);
    rx(8'h00);
    wait_send("f4", 8'hF4, 0);
    check("st_sen", 32'(MASTER_STATE), 32'd6);
    ack_sent();
    check("st_ack2", 32'(MASTER_STATE), 32'd8);
    rx(8'hFA);
    check("st_rd", 32'(MASTER_STATE), 32'd9);

    // Packet 09 05 FB with latency checks
    rx(8'h09);
    rx(8'h05);
    rx(8'hFB);
    check("pk_old", mouse(), 32'd0);
    check("pk_int", 32'(MASTER_STATE), 32'd12);
    tick();
    check("pk_data", mouse(), 32'h0905FB);
    check("pk_irq_e", 32'(SEND_INTERRUPT), 32'd0);
    tick();
    check("pk_irq", 32'(SEND_INTERRUPT), 32'd1);
    tick();
    check("pk_irq_l", 32'(SEND_INTERRUPT), 32'd0);
    check("pk_back", 32'(MASTER_STATE), 32'd9);
    check("pk_cnt", 32'(irq_cnt), 32'd1);

    // Resync: no sync bit is ignored
    rx(8'h00);
    check("rs_stay", 32'(MASTER_STATE), 32'd9);
    rx(8'h08);
    rx(8'h01);
    rx(8'h02);
    tick(3);
    check("rs_data", mouse(), 32'h080102);
    check("rs_cnt", 32'(irq_cnt), 32'd2);

    // Parity error on DX discards the packet
    rx(8'h09);
    rx(8'h05, 2'b01);
    check("par_st", 32'(MASTER_STATE), 32'd9);
    tick(5);
    check("par_data", mouse(), 32'h080102);
    check("par_cnt", 32'(irq_cnt), 32'd2);
    rx(8'h0C);
    rx(8'h10);
    rx(8'h20);
    tick(3);
    check("par_rec", mouse(), 32'h0C1020);

    // Mid-packet stream timeout
    rx(8'h09);
    check("sto_dx", 32'(MASTER_STATE), 32'd10);
    tick(TO + 5);
    check("sto_st", 32'(MASTER_STATE), 32'd9);
    check("sto_data", mouse(), 32'h0C1020);
    check("sto_cnt", 32'(irq_cnt), 32'd3);

    // Bad ack forces a full retry
    do_reset();
    wait_send("ba_ff", 8'hFF, INIT);
    ack_sent();
    rx(8'hFE);
    check("ba_st", 32'(MASTER_STATE), 32'd0);
    wait_send("ba_retry", 8'hFF, INIT);

    // No response after FF
    do_reset();
    wait_send("to_ff", 8'hFF, INIT);
    ack_sent();
    wait_idle("to_ack", TO);

    // BYTE_SENT never arrives
    do_reset();
    wait_send("ts_ff", 8'hFF, INIT);
    tick();
    wait_idle("to_sent", TO);

    // Reset while SEND_BYTE is high
    do_reset();
    wait_send("rsnd", 8'hFF, INIT);
    RESET = 1'b1;
    #1;
    check("rsnd_send", 32'(SEND_BYTE), 32'd0);
    check("rsnd_st", 32'(MASTER_STATE), 32'd0);

    // Reset in the middle of DY
    do_reset();
    do_init();
    rx(8'h18);
    rx(8'h22);
    rx(8'h33);
    tick(3);
    check("rdy_pre", mouse(), 32'h182233);
    rx(8'h08);
    rx(8'h44);
    check("rdy_st", 32'(MASTER_STATE), 32'd11);
    RESET = 1'b1;
    #1;
    check("rdy_mouse", mouse(), 32'd0);
    check("rdy_state", 32'(MASTER_STATE), 32'd0);
    check("rdy_re", 32'(READ_ENABLE), 32'd0);
    check("rdy_irq", 32'(SEND_INTERRUPT), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
